apb_tx_cfg_master: RTL

APB master that sequences one complete frame-transmit configuration into the TX register block. A requester hands over one descriptor (prescale, ID, data field, transmit word, command). The master then issues the write sequence, polls status until the TX FIFO has room, queues the transmit word, and kicks the command register. It sits between the host/test sequencer and the TX APB slave, and is the only master on that APB segment.

---
 rtl/tx_apb_pkg.sv | 57 +++++
 rtl/apb_tx_cfg_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tx_apb_pkg.sv
// Purpose    : shared register map, status bit position and FSM encodings for the TX config master.
// Latency    : n/a (declarations only).
// Backpressure: n/a.
// Contents   : register address constants, status bit index, state/step enums, step decode helpers.
package tx_apb_pkg;

  // TX slave register map (byte addresses on the APB segment)
  localparam int ADDR_PRESCALE = 0;
  localparam int ADDR_COMMAND  = 4;
  localparam int ADDR_TRANSMIT = 8;
  localparam int ADDR_ID       = 12;
  localparam int ADDR_DATA     = 16;
  localparam int ADDR_STATUS   = 20;

  // Status word: set while the TX FIFO cannot take another word
  localparam int STATUS_FIFO_FULL_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR
  } state_e;

  // Transfer order of one descriptor; the encoding is also the issue order
  typedef enum logic [2:0] {
    STEP_PRESCALE,
    STEP_ID,
    STEP_DATA,
    STEP_STATUS,
    STEP_TRANSMIT,
    STEP_COMMAND
  } step_e;

  // Register address targeted by a step
  function automatic int step_addr(step_e s);
    int a;
    a = ADDR_PRESCALE;
    case (s)
      STEP_PRESCALE: a = ADDR_PRESCALE;
      STEP_ID:       a = ADDR_ID;
      STEP_DATA:     a = ADDR_DATA;
      STEP_STATUS:   a = ADDR_STATUS;
      STEP_TRANSMIT: a = ADDR_TRANSMIT;
      STEP_COMMAND:  a = ADDR_COMMAND;
      default:       a = ADDR_PRESCALE;
    endcase
    return a;
  endfunction

  // Only the status poll is a read; every other step writes
  function automatic logic step_is_write(step_e s);
    return (s != STEP_STATUS);
  endfunction

endpackage

// File: rtl/apb_tx_cfg_master.sv
// Purpose    : APB master that writes one TX frame configuration, polls FIFO status, queues the word, kicks the command.
// Latency    : 2 cycles per APB transfer (+1 per PREADY wait); 13 cycles handshake-to-done with a clear first poll.
// Backpressure: req_ready only in IDLE; PREADY low stretches ACCESS; status poll aborts after MAX_POLL full reads.
// Ports      : PCLK_tx/PRESETn_tx clock and async active-low reset; req_* descriptor valid/ready handshake;
//              PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY APB master side;
//              busy (descriptor in flight), done/err (1-cycle completion/abort pulses), last_status (last status read).
module apb_tx_cfg_master
  import tx_apb_pkg::*;
#(
  parameter int ADDRESSWIDTH = 5,
  parameter int DATAWIDTH    = 16,
  parameter int MAX_POLL     = 16,
  parameter int POLL_W       = 5
) (
  input  logic                    PCLK_tx,
  input  logic                    PRESETn_tx,
  // descriptor handshake
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [15:0]             req_prescale,
  input  logic [15:0]             req_id,
  input  logic [15:0]             req_data,
  input  logic [11:0]             req_transmit,
  input  logic [7:0]              req_command,
  // APB master
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY,
  // status
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             last_status
);

  state_e              state_q, state_d;
  step_e               step_q, step_d;
  logic [15:0]         prescale_q, prescale_d;
  logic [15:0]         id_q, id_d;
  logic [15:0]         data_q, data_d;
  logic [11:0]         transmit_q, transmit_d;
  logic [7:0]          command_q, command_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [15:0]         last_status_q, last_status_d;

  logic [POLL_W-1:0]   poll_inc;
  logic                apb_active;
  logic [ADDRESSWIDTH-1:0] xfer_addr;
  logic [DATAWIDTH-1:0]    xfer_wdata;
  logic                    xfer_write;

  assign poll_inc = poll_q + POLL_W'(1);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
    if (!PRESETn_tx) begin
      state_q       <= ST_IDLE;
      step_q        <= STEP_PRESCALE;
      prescale_q    <= '0;
      id_q          <= '0;
      data_q        <= '0;
      transmit_q    <= '0;
      command_q     <= '0;
      poll_q        <= '0;
      last_status_q <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      prescale_q    <= prescale_d;
      id_q          <= id_d;
      data_q        <= data_d;
      transmit_q    <= transmit_d;
      command_q     <= command_d;
      poll_q        <= poll_d;
      last_status_q <= last_status_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    prescale_d    = prescale_q;
    id_d          = id_q;
    data_d        = data_q;
    transmit_d    = transmit_q;
    command_d     = command_q;
    poll_d        = poll_q;
    last_status_d = last_status_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          prescale_d = req_prescale;
          id_d       = req_id;
          data_d     = req_data;
          transmit_d = req_transmit;
          command_d  = req_command;
          step_d     = STEP_PRESCALE;
          poll_d     = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: state_d = ST_ACCESS;

      ST_ACCESS: begin
        if (PREADY) begin
          // Default for write steps: next transfer follows immediately
          state_d = ST_SETUP;
          case (step_q)
            STEP_PRESCALE: step_d = STEP_ID;
            STEP_ID:       step_d = STEP_DATA;
            STEP_DATA:     step_d = STEP_STATUS;
            STEP_STATUS: begin
              last_status_d = 16'(PRDATA);
              poll_d        = poll_inc;
              if (!PRDATA[STATUS_FIFO_FULL_BIT]) begin
                step_d = STEP_TRANSMIT;
              end else if (poll_inc == POLL_W'(MAX_POLL)) begin
                // FIFO never drained: abandon before touching TRANSMIT/COMMAND
                state_d = ST_ERR;
              end
              // otherwise stay on STEP_STATUS and re-poll back-to-back
            end
            STEP_TRANSMIT: step_d  = STEP_COMMAND;
            STEP_COMMAND:  state_d = ST_DONE;
            default:       state_d = ST_ERR;
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Step -> APB address / direction / write data
  // ------------------------------------------------------------------
  always_comb begin
    xfer_addr  = ADDRESSWIDTH'(step_addr(step_q));
    xfer_write = step_is_write(step_q);
    xfer_wdata = '0;
    case (step_q)
      STEP_PRESCALE: xfer_wdata = DATAWIDTH'(prescale_q);
      STEP_ID:       xfer_wdata = DATAWIDTH'(id_q);
      STEP_DATA:     xfer_wdata = DATAWIDTH'(data_q);
      STEP_TRANSMIT: xfer_wdata = DATAWIDTH'(transmit_q);
      STEP_COMMAND:  xfer_wdata = DATAWIDTH'(command_q);
      default:       xfer_wdata = '0;  // status read drives zero
    endcase
  end

  // Bus fields are forced to zero outside a transfer so the segment is
  // quiet in IDLE/DONE/ERR and reads as reset values.
  assign apb_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  assign PSEL    = apb_active;
  assign PENABLE = (state_q == ST_ACCESS);
  assign PADDR   = apb_active ? xfer_addr  : '0;
  assign PWRITE  = apb_active ? xfer_write : 1'b0;
  assign PWDATA  = apb_active ? xfer_wdata : '0;

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);
  assign last_status = last_status_q;

endmodule
